// File: rtl/font_pipe_renderer_pkg.sv
// font_pipe_renderer_pkg
//   Shared definitions for the text-mode glyph renderer:
//   - attribute bit positions within the 3-bit attr field
//   - default glyph geometry and colour width
//   - clog2 helper used for port and address widths
//   - built-in glyph pattern used as the ROM contents
package font_pipe_renderer_pkg;

    localparam int unsigned ATTR_INVERT    = 0;
    localparam int unsigned ATTR_UNDERLINE = 1;
    localparam int unsigned ATTR_BLINK     = 2;

    localparam int unsigned DEF_CHAR_W  = 8;
    localparam int unsigned DEF_CHAR_H  = 16;
    localparam int unsigned DEF_COLOR_W = 12;

    // Ceiling log2, never below 1 so that 1-entry ranges still get a 1-bit field.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Deterministic built-in font: character 0x20 (space) is blank, every
    // other cell gets a scrambled pattern derived from its code and row.
    function automatic logic [15:0] default_glyph(input logic [31:0] addr,
                                                  input int unsigned char_h);
        logic [31:0] code;
        logic [31:0] row;
        logic [31:0] x;
        code = addr / char_h;
        row  = addr % char_h;
        x    = code * 32'd131 + row * 32'd29 + 32'd7;
        if (code == 32'd32) begin
            return '0;
        end
        return 16'(x ^ (x >> 3) ^ (x << 5));
    endfunction

endpackage

// File: rtl/font_pipe_renderer_rom.sv
// font_rom_sync
//   Synchronous-read glyph ROM, 256*CHAR_H words of CHAR_W bits, one cycle
//   of read latency. Contents come from the package's built-in pattern;
//   INIT_FILE is kept for interface compatibility. No reset: contents are constant.
// Ports:
//   clk   system clock
//   addr  word address (ascii_code*CHAR_H + row)
//   data  word read at the previous rising edge
module font_rom_sync
    import font_pipe_renderer_pkg::*;
#(
    parameter int unsigned CHAR_W    = DEF_CHAR_W,
    parameter int unsigned CHAR_H    = DEF_CHAR_H,
    parameter string       INIT_FILE = ""
)(
    input  logic                           clk,
    input  logic [clog2(256*CHAR_H)-1:0]   addr,
    output logic [CHAR_W-1:0]              data
);

    always_ff @(posedge clk) begin
        data <= CHAR_W'(default_glyph(32'(addr), CHAR_H));
    end

endmodule

// File: rtl/font_pipe_renderer.sv
// font_pipe_renderer
//   Two-stage text-mode pixel pipeline: looks up a glyph row in the font ROM,
//   picks the requested column bit and applies underline, blink, invert and
//   cursor rules. One request per cycle, fixed 2-cycle latency, no stalls.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid                  request qualifier
//   ascii_code                character code
//   row_in_char, col_in_char  pixel position inside the glyph cell
//   fg_color, bg_color        colours for lit / unlit pixels
//   attr                      [0] invert, [1] underline, [2] blink
//   cursor_here               cell holds the cursor
//   frame_start               one-cycle pulse per video frame (blink timebase)
//   out_valid                 pixel_on / pixel_rgb valid (held otherwise)
//   pixel_on                  final foreground decision
//   pixel_rgb                 final colour
module font_pipe_renderer
    import font_pipe_renderer_pkg::*;
#(
    parameter int unsigned CHAR_W        = DEF_CHAR_W,
    parameter int unsigned CHAR_H        = DEF_CHAR_H,
    parameter int unsigned COLOR_W       = DEF_COLOR_W,
    parameter int unsigned BLINK_DIV     = 30,
    parameter string       ROM_INIT_FILE = ""
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 ascii_code,
    input  logic [clog2(CHAR_H)-1:0]   row_in_char,
    input  logic [clog2(CHAR_W)-1:0]   col_in_char,
    input  logic [COLOR_W-1:0]         fg_color,
    input  logic [COLOR_W-1:0]         bg_color,
    input  logic [2:0]                 attr,
    input  logic                       cursor_here,
    input  logic                       frame_start,
    output logic                       out_valid,
    output logic                       pixel_on,
    output logic [COLOR_W-1:0]         pixel_rgb
);

    localparam int unsigned RW = clog2(CHAR_H);
    localparam int unsigned CW = clog2(CHAR_W);
    localparam int unsigned AW = clog2(256 * CHAR_H);
    localparam int unsigned BW = clog2(BLINK_DIV);

    // Blink timebase
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage 1: address generation and sideband capture
    logic               row_ok;
    logic [AW-1:0]      addr_next;

    always_comb begin
        row_ok    = 32'(row_in_char) < CHAR_H;
        // Out-of-range rows would alias into the next character; park them at 0.
        addr_next = row_ok ? AW'(32'(ascii_code) * CHAR_H + 32'(row_in_char)) : '0;
    end

    logic               v1;
    logic [AW-1:0]      addr1;
    logic               row_ok1;
    logic [RW-1:0]      row1;
    logic [CW-1:0]      col1;
    logic [COLOR_W-1:0] fg1;
    logic [COLOR_W-1:0] bg1;
    logic [2:0]         attr1;
    logic               cur1;
    logic               ph1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            addr1   <= '0;
            row_ok1 <= 1'b0;
            row1    <= '0;
            col1    <= '0;
            fg1     <= '0;
            bg1     <= '0;
            attr1   <= '0;
            cur1    <= 1'b0;
            ph1     <= 1'b0;
        end else begin
            v1      <= in_valid;
            addr1   <= addr_next;
            row_ok1 <= row_ok;
            row1    <= row_in_char;
            col1    <= col_in_char;
            fg1     <= fg_color;
            bg1     <= bg_color;
            attr1   <= attr;
            cur1    <= cursor_here;
            ph1     <= blink_phase;  // pre-update phase when frame_start coincides
        end
    end

    // Stage 2: ROM read; sideband is delayed one more cycle to line up with it
    logic [CHAR_W-1:0]  rom_data;

    font_rom_sync #(
        .CHAR_W    (CHAR_W),
        .CHAR_H    (CHAR_H),
        .INIT_FILE (ROM_INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (addr1),
        .data (rom_data)
    );

    logic               v2;
    logic               row_ok2;
    logic [RW-1:0]      row2;
    logic [CW-1:0]      col2;
    logic [COLOR_W-1:0] fg2;
    logic [COLOR_W-1:0] bg2;
    logic [2:0]         attr2;
    logic               cur2;
    logic               ph2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            row_ok2 <= 1'b0;
            row2    <= '0;
            col2    <= '0;
            fg2     <= '0;
            bg2     <= '0;
            attr2   <= '0;
            cur2    <= 1'b0;
            ph2     <= 1'b0;
        end else begin
            v2      <= v1;
            row_ok2 <= row_ok1;
            row2    <= row1;
            col2    <= col1;
            fg2     <= fg1;
            bg2     <= bg1;
            attr2   <= attr1;
            cur2    <= cur1;
            ph2     <= ph1;
        end
    end

    // Pixel decision
    logic glyph_bit;
    logic g;

    always_comb begin
        // MSB is the leftmost pixel; columns >= CHAR_W match no bit and stay 0.
        glyph_bit = 1'b0;
        for (int unsigned i = 0; i < CHAR_W; i++) begin
            if (row_ok2 && (32'(col2) == CHAR_W - 1 - i)) begin
                glyph_bit = rom_data[i];
            end
        end

        g = glyph_bit;
        if (attr2[ATTR_UNDERLINE] && (32'(row2) == CHAR_H - 1)) begin
            g = 1'b1;
        end
        if (attr2[ATTR_BLINK] && ph2) begin
            g = 1'b0;
        end
        if (attr2[ATTR_INVERT]) begin
            g = ~g;
        end
        if (cur2 && !ph2 && (32'(row2) + 32'd2 >= CHAR_H)) begin
            g = ~g;
        end
    end

    // Output register: holds its value while no request is emerging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            pixel_on  <= 1'b0;
            pixel_rgb <= '0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                pixel_on  <= g;
                pixel_rgb <= g ? fg2 : bg2;
            end
        end
    end

endmodule

// File: tb/tb_font_pipe_renderer.sv
module tb_font_pipe_renderer;

    localparam int CW_PIX = 6;   // glyph width (exercises col >= CHAR_W)
    localparam int CH     = 12;  // glyph height (exercises row >= CHAR_H)
    localparam int RW     = 4;
    localparam int CWB    = 3;
    localparam int BD     = 2;
    localparam int COLW   = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       ascii_code = '0;
    logic [RW-1:0]    row_in_char = '0;
    logic [CWB-1:0]   col_in_char = '0;
    logic [COLW-1:0]  fg_color = '0;
    logic [COLW-1:0]  bg_color = '0;
    logic [2:0]       attr = '0;
    logic             cursor_here = 1'b0;
    logic             frame_start = 1'b0;
    logic             out_valid;
    logic             pixel_on;
    logic [COLW-1:0]  pixel_rgb;

    font_pipe_renderer #(
        .CHAR_W    (CW_PIX),
        .CHAR_H    (CH),
        .COLOR_W   (COLW),
        .BLINK_DIV (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .ascii_code  (ascii_code),
        .row_in_char (row_in_char),
        .col_in_char (col_in_char),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .attr        (attr),
        .cursor_here (cursor_here),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .pixel_on    (pixel_on),
        .pixel_rgb   (pixel_rgb)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              on;
        logic [COLW-1:0] rgb;
        int unsigned     issue;
    } exp_t;

    exp_t sb[$];
    int   pulses = 0;   // frame_start pulses since reset

    function automatic int unsigned font_word(int code, int row);
        int unsigned x;
        if (code == 32) return 0;
        x = code * 131 + row * 29 + 7;
        return (x ^ (x >> 3) ^ (x << 5)) & 32'hFFFF;
    endfunction

    function automatic bit cur_phase();
        return ((pulses / BD) % 2) == 1;
    endfunction

    function automatic exp_t model(int code, int row, int col, logic [COLW-1:0] fg,
                                   logic [COLW-1:0] bg, logic [2:0] at, bit cur, bit ph);
        exp_t e;
        bit   g;
        g = 0;
        if (row < CH && col < CW_PIX)
            g = (font_word(code, row) >> (CW_PIX - 1 - col)) & 1;
        if (at[1] && row == CH - 1) g = 1;
        if (at[2] && ph) g = 0;
        if (at[0]) g = !g;
        if (cur && !ph && row >= CH - 2) g = !g;
        e.on  = g;
        e.rgb = g ? fg : bg;
        e.issue = 0;
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge; the request is taken at the following rising edge.
    task automatic drive(input bit v, input int code, input int row, input int col,
                         input logic [COLW-1:0] fg, input logic [COLW-1:0] bg,
                         input logic [2:0] at, input bit cur, input bit fs);
        exp_t e;
        in_valid    = v;
        ascii_code  = 8'(code);
        row_in_char = RW'(row);
        col_in_char = CWB'(col);
        fg_color    = fg;
        bg_color    = bg;
        attr        = at;
        cursor_here = cur;
        frame_start = fs;
        if (v) begin
            e = model(code, row, col, fg, bg, at, cur, cur_phase());
            e.issue = cyc;
            sb.push_back(e);
        end
        if (fs) pulses++;
        @(negedge clk);
    endtask

    task automatic idle(input bit fs);
        drive(0, 0, 0, 0, '0, '0, 3'b000, 0, fs);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_pixel_rgb", pixel_rgb, 0);
        chk("rst_async_pixel_on",  pixel_on, 0);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        sb.delete();
        pulses = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    bit              last_on  = 0;
    logic [COLW-1:0] last_rgb = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_on  = 0;
            last_rgb = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - e.issue, 3);
                chk("pixel_on", pixel_on, e.on);
                chk("pixel_rgb", pixel_rgb, e.rgb);
            end
            last_on  = pixel_on;
            last_rgb = pixel_rgb;
        end else begin
            chk("hold_pixel_on", pixel_on, last_on);
            chk("hold_pixel_rgb", pixel_rgb, last_rgb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [COLW-1:0] fg;
        logic [COLW-1:0] bg;

        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_pixel_on", pixel_on, 0);
        chk("reset_pixel_rgb", pixel_rgb, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // 'A', row 5, every column back to back, plain attributes
        for (int c = 0; c < 8; c++)
            drive(1, 8'h41, 5, c, 12'hF0F, 12'h0A0, 3'b000, 0, 0);

        // Underline on a blank cell: last row lit everywhere, next-to-last not
        for (int c = 0; c < 8; c++)
            drive(1, 8'h20, CH - 1, c, 12'hABC, 12'h123, 3'b010, 0, 0);
        for (int c = 0; c < 8; c++)
            drive(1, 8'h20, CH - 2, c, 12'hABC, 12'h123, 3'b010, 0, 0);

        // Cursor in phase 0 on the bottom two rows, not above
        for (int r = CH - 3; r < CH; r++)
            drive(1, 8'h20, r, 2, 12'h777, 12'h001, 3'b000, 1, 0);

        // Blink over four frames; first request of each frame shares the pulse
        for (int f = 0; f < 4; f++) begin
            drive(1, 8'h41, 5, 0, 12'h111, 12'h222, 3'b100, 0, 1);
            for (int c = 1; c < CW_PIX; c++)
                drive(1, 8'h41, 5, c, 12'h111, 12'h222, 3'b100, 0, 0);
            idle(0);
        end

        // Into phase 1, cursor suppressed
        idle(1);
        idle(1);
        for (int r = CH - 3; r < CH; r++)
            drive(1, 8'h20, r, 2, 12'h777, 12'h001, 3'b000, 1, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            fg = COLW'($urandom);
            bg = COLW'($urandom);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? 8'h20 : int'($urandom_range(0, 255)),
                  $urandom_range(0, 15), $urandom_range(0, 7), fg, bg,
                  3'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end

        // Leave the blink counter mid-period, then reset with a request on the bus
        if (pulses % BD == 0) idle(1);
        for (int c = 0; c < 4; c++)
            drive(1, 8'h41, 3, c, 12'hFFF, 12'h800, 3'b001, 0, 0);
        mid_reset();

        // Counter must restart at 0: one pulse keeps phase 0, second toggles
        drive(1, 8'h41, 5, 1, 12'h0F0, 12'h00F, 3'b100, 1, 1);
        drive(1, 8'h20, CH - 1, 1, 12'h0F0, 12'h00F, 3'b100, 1, 0);
        drive(1, 8'h20, CH - 1, 1, 12'h0F0, 12'h00F, 3'b101, 1, 1);
        drive(1, 8'h20, CH - 1, 1, 12'h0F0, 12'h00F, 3'b101, 1, 0);

        for (int i = 0; i < 150; i++) begin
            fg = COLW'($urandom);
            bg = COLW'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                  $urandom_range(0, 15), $urandom_range(0, 7), fg, bg,
                  3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        end

        // Drain with a bounded wait
        idle(0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
